// File: rtl/freq_counter_pkg.sv
// Shared types and helpers for the multi-channel frequency counter.
// Holds the FSM encodings, synchroniser depth and channel-index width.
package freq_counter_pkg;

    typedef enum logic {
        STOPPED  = 1'b0,
        COUNTING = 1'b1
    } gate_state_t;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_t;

    localparam int SYNC_STAGES = 2;

    // Channel index width; a single channel still gets one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/freq_counter_mc_if.sv
// Result stream bundle: one channel count per beat, valid/ready.
// Ports: res_valid, res_data, res_ch, res_ovf (producer), res_ready (consumer).
interface freq_counter_mc_if #(
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
);
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_data;
    logic [CH_W-1:0]  res_ch;
    logic             res_ovf;

    modport master (
        output res_valid,
        output res_data,
        output res_ch,
        output res_ovf,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_ch,
        input  res_ovf,
        output res_ready
    );
endinterface

// File: rtl/freq_edge_counter.sv
// One channel: synchroniser, rising-edge detect, saturating counter, ovf.
// Ports: clk, rst_n, sig (async in), clear, count/ovf (value incl. this cycle).
module freq_edge_counter
    import freq_counter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

    // count/ovf already include this cycle's pulse, so a snapshot taken
    // in the window-end cycle keeps an edge arriving in that cycle.
    assign count = (pulse && (cnt_q != MAX)) ? cnt_q + 1'b1 : cnt_q;
    assign ovf   = ovf_q | (count == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            prev_q <= sync_q[SYNC_STAGES-1];
            cnt_q  <= clear ? '0 : count;
            ovf_q  <= clear ? 1'b0 : ovf;
        end
    end

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel frequency counter: shared gate window, snapshot, stream out.
// Ports: clk, rst_n, ena, sig_in, period_in/_load, gate_active, res, overrun, dbg_state.
module freq_counter_mc
    import freq_counter_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int PERIOD_W       = 24,
    parameter int DEFAULT_PERIOD = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NUM_CH-1:0]   sig_in,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_load,
    output logic                gate_active,
    freq_counter_mc_if.master   res,
    output logic                overrun,
    output logic [1:0]          dbg_state
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam logic [PERIOD_W-1:0] DEF_P = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    gate_state_t         gate_q, gate_d;
    out_state_t          out_q, out_d;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_eff;
    logic [PERIOD_W-1:0] win_len_q, win_len_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                ovr_q, ovr_d;
    logic                win_end;
    logic                clear;
    logic                snap_en;
    logic                xfer;

    logic [CNT_W-1:0]    live_cnt [NUM_CH];
    logic [NUM_CH-1:0]   live_ovf;
    logic [CNT_W-1:0]    snap_cnt [NUM_CH];
    logic [NUM_CH-1:0]   snap_ovf;

    // A zero period would never reach timer==P-1; run it as one cycle.
    assign period_eff = (period_q == '0) ? PERIOD_W'(1) : period_q;

    assign win_end = (gate_q == COUNTING) && ena
                   && (timer_q == win_len_q - 1'b1);

    // Counters only accumulate inside a live window.
    assign clear = win_end || !((gate_q == COUNTING) && ena);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        freq_edge_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .sig   (sig_in[i]),
            .clear (clear),
            .count (live_cnt[i]),
            .ovf   (live_ovf[i])
        );
    end

    // Gate FSM: window length latched at each window start.
    always_comb begin
        gate_d    = gate_q;
        timer_d   = timer_q;
        win_len_d = win_len_q;
        unique case (gate_q)
            STOPPED: begin
                if (ena) begin
                    gate_d    = COUNTING;
                    timer_d   = '0;
                    win_len_d = period_eff;
                end
            end
            COUNTING: begin
                if (!ena) begin
                    gate_d  = STOPPED;
                    timer_d = '0;
                end else if (win_end) begin
                    timer_d   = '0;
                    win_len_d = period_eff;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
    end

    assign xfer = (out_q == OUT_SEND) && res.res_ready;

    // Output FSM: a window end during a stream drops that snapshot.
    always_comb begin
        out_d   = out_q;
        ch_d    = ch_q;
        ovr_d   = ovr_q;
        snap_en = 1'b0;
        unique case (out_q)
            OUT_IDLE: begin
                if (win_end) begin
                    out_d   = OUT_SEND;
                    ch_d    = '0;
                    snap_en = 1'b1;
                end
            end
            OUT_SEND: begin
                if (win_end) begin
                    ovr_d = 1'b1;
                end
                if (xfer) begin
                    if (ch_q == LAST_CH) begin
                        out_d = OUT_IDLE;
                        ch_d  = '0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
        endcase
        if (!ena) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q    <= STOPPED;
            out_q     <= OUT_IDLE;
            timer_q   <= '0;
            win_len_q <= '0;
            period_q  <= DEF_P;
            ch_q      <= '0;
            ovr_q     <= 1'b0;
        end else begin
            gate_q    <= gate_d;
            out_q     <= out_d;
            timer_q   <= timer_d;
            win_len_q <= win_len_d;
            ch_q      <= ch_d;
            ovr_q     <= ovr_d;
            if (period_load) begin
                period_q <= period_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_cnt[i] <= '0;
            end
            snap_ovf <= '0;
        end else if (snap_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_cnt[i] <= live_cnt[i];
            end
            snap_ovf <= live_ovf;
        end
    end

    assign res.res_valid = (out_q == OUT_SEND);
    assign res.res_ch    = ch_q;
    assign res.res_data  = res.res_valid ? snap_cnt[ch_q] : '0;
    assign res.res_ovf   = res.res_valid & snap_ovf[ch_q];

    assign gate_active = (gate_q == COUNTING);
    assign overrun     = ovr_q;
    assign dbg_state   = {gate_q == COUNTING, out_q == OUT_SEND};

endmodule

// File: tb/tb_freq_counter_mc.sv
// Randomised scoreboard bench for freq_counter_mc.
// Reference model works on edge arrival times and window bounds.
module tb_freq_counter_mc;
    import freq_counter_pkg::*;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 6;
    localparam int PERIOD_W = 8;
    localparam int DEF_P    = 100;
    localparam int CH_W     = ch_width(NUM_CH);
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ena = 1'b0;
    logic                period_load = 1'b0;
    logic [NUM_CH-1:0]   sig_in = '0;
    logic [PERIOD_W-1:0] period_in = '0;
    logic                gate_active;
    logic                overrun;
    logic [1:0]          dbg_state;

    freq_counter_mc_if #(.CNT_W(CNT_W), .CH_W(CH_W)) res_if ();

    freq_counter_mc #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .PERIOD_W       (PERIOD_W),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .sig_in      (sig_in),
        .period_in   (period_in),
        .period_load (period_load),
        .gate_active (gate_active),
        .res         (res_if),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int ch;
        int data;
        int ovf;
        int rise;
    } beat_t;

    beat_t exp_q[$];

    // ---------------- reference model ----------------
    int  cyc = 0;
    int  preg = DEF_P;
    int  win_start, win_len;
    int  remaining = 0;
    bit  running = 0;
    bit  m_ovr = 0;
    bit  busy;
    int  mcnt [NUM_CH];
    int  land_q [NUM_CH][$];
    logic [NUM_CH-1:0] prev_sig = '0;
    beat_t nb;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            running   = 0;
            m_ovr     = 0;
            remaining = 0;
            preg      = DEF_P;
            prev_sig  = '0;
            exp_q.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                land_q[c].delete();
                mcnt[c] = 0;
            end
        end else begin
            busy = (remaining > 0);
            if (remaining > 0 && res_if.res_ready) remaining--;
            for (int c = 0; c < NUM_CH; c++) begin
                while (land_q[c].size() > 0 && land_q[c][0] == cyc) begin
                    void'(land_q[c].pop_front());
                    if (running && cyc >= win_start) mcnt[c]++;
                end
            end
            if (!ena) begin
                running = 0;
                m_ovr   = 0;
            end else if (!running) begin
                running   = 1;
                win_start = cyc + 1;
                win_len   = (preg == 0) ? 1 : preg;
                for (int c = 0; c < NUM_CH; c++) mcnt[c] = 0;
            end else if (cyc == win_start + win_len - 1) begin
                if (busy) begin
                    m_ovr = 1;
                end else begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        nb.ch   = c;
                        nb.data = (mcnt[c] > MAXC) ? MAXC : mcnt[c];
                        nb.ovf  = (mcnt[c] >= MAXC) ? 1 : 0;
                        nb.rise = cyc;
                        exp_q.push_back(nb);
                    end
                    remaining = NUM_CH;
                end
                win_start = cyc + 1;
                win_len   = (preg == 0) ? 1 : preg;
                for (int c = 0; c < NUM_CH; c++) mcnt[c] = 0;
            end
            if (period_load) preg = int'(period_in);
            for (int c = 0; c < NUM_CH; c++) begin
                if (sig_in[c] && !prev_sig[c]) land_q[c].push_back(cyc + 2);
            end
            prev_sig = sig_in;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit    pv = 0;
    bit    pr = 0;
    int    pd, pc, po;
    int    nbeats = 0;
    int    sat_seen = 0;
    beat_t eb;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 0;
        end else begin
            chk("gate_active", int'(gate_active), int'(running));
            chk("dbg_gate", int'(dbg_state[1]), int'(running));
            chk("dbg_out", int'(dbg_state[0]), int'(remaining > 0));
            chk("res_valid", int'(res_if.res_valid), int'(remaining > 0));
            chk("overrun", int'(overrun), int'(m_ovr));
            if (res_if.res_valid && !pv) begin
                if (exp_q.size() == 0) chk("valid_unexpected", 1, 0);
                else chk("valid_rise_cycle", cyc, exp_q[0].rise);
            end
            if (res_if.res_valid && pv && !pr) begin
                chk("hold_data", int'(res_if.res_data), pd);
                chk("hold_ch", int'(res_if.res_ch), pc);
                chk("hold_ovf", int'(res_if.res_ovf), po);
            end
            if (res_if.res_valid && res_if.res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    eb = exp_q.pop_front();
                    chk("beat_ch", int'(res_if.res_ch), eb.ch);
                    chk("beat_data", int'(res_if.res_data), eb.data);
                    chk("beat_ovf", int'(res_if.res_ovf), eb.ovf);
                    nbeats++;
                    if (eb.ovf == 1 && eb.data == MAXC) sat_seen++;
                end
            end
            pv = res_if.res_valid;
            pr = res_if.res_ready;
            pd = int'(res_if.res_data);
            pc = int'(res_if.res_ch);
            po = int'(res_if.res_ovf);
        end
    end

    // ---------------- input drivers ----------------
    int half [NUM_CH];
    int phase [NUM_CH];
    bit sig_rand = 0;
    int rdy_mode = 0;
    int bp_cnt = 0;
    bit bp_seen = 0;

    always @(posedge clk) begin
        #2;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sig_rand) begin
                sig_in[c] = 1'($urandom_range(0, 1));
            end else if (half[c] == 0) begin
                sig_in[c] = 1'b0;
            end else begin
                phase[c]++;
                if (phase[c] >= half[c]) begin
                    phase[c]  = 0;
                    sig_in[c] = ~sig_in[c];
                end
            end
        end
        case (rdy_mode)
            0: res_if.res_ready = 1'b1;
            1: res_if.res_ready = 1'b0;
            2: res_if.res_ready = 1'($urandom_range(0, 1));
            default: begin
                if (res_if.res_valid && !bp_seen) begin
                    bp_seen = 1;
                    bp_cnt  = 5;
                end
                if (!res_if.res_valid) bp_seen = 0;
                res_if.res_ready = (bp_cnt == 0);
                if (bp_cnt > 0) bp_cnt--;
            end
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_period(input int v);
        period_in   = PERIOD_W'(v);
        period_load = 1'b1;
        step(1);
        period_load = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(res_if.res_valid), 0);
        chk({tag, "_data"}, int'(res_if.res_data), 0);
        chk({tag, "_ch"}, int'(res_if.res_ch), 0);
        chk({tag, "_ovf"}, int'(res_if.res_ovf), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_gate"}, int'(gate_active), 0);
        chk({tag, "_dbg"}, int'(dbg_state), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    int t0;
    int k;

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            half[c]  = 0;
            phase[c] = 0;
        end
        rst_n = 1'b0;
        step(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        step(2);

        // basic count: ch0 edge every 10 clk, ch1 low
        half[0] = 5;
        ena = 1'b1;
        step(450);

        // backpressure: ready low 5 cycles after each valid rise
        rdy_mode = 3;
        step(320);

        // period change mid-window keeps current length
        rdy_mode = 0;
        step(37);
        load_period(50);
        step(250);

        // random traffic, random short periods incl. 0
        sig_rand = 1;
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            load_period($urandom_range(0, 12));
            step($urandom_range(40, 120));
        end

        // one-clock windows while streaming
        sig_rand = 0;
        half[0] = 2;
        load_period(0);
        step(60);
        chk("overrun_p0", int'(overrun), 1);

        // saturation
        ena = 1'b0;
        rdy_mode = 0;
        half[0] = 1;
        load_period(200);
        ena = 1'b1;
        step(650);
        chk("saturated_beat_seen", int'(sat_seen > 0), 1);

        // overrun with ready held low
        ena = 1'b0;
        half[0] = 5;
        load_period(100);
        rdy_mode = 1;
        step(1);
        ena = 1'b1;
        step(230);
        chk("overrun_set", int'(overrun), 1);
        rdy_mode = 0;
        step(20);
        ena = 1'b0;
        step(2);
        chk("overrun_clear", int'(overrun), 0);

        // reset mid-stream after loading a non-default period
        load_period(40);
        rdy_mode = 1;
        ena = 1'b1;
        k = 0;
        while (!res_if.res_valid && k < 400) begin
            step(1);
            k++;
        end
        chk("stream_started", int'(res_if.res_valid), 1);
        chk("stream_ch0", int'(res_if.res_ch), 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        ena = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("post_reset_dbg", int'(dbg_state), 0);
        rdy_mode = 0;
        ena = 1'b1;
        t0 = cyc;
        k = 0;
        while (!res_if.res_valid && k < 400) begin
            step(1);
            k++;
        end
        chk("period_after_reset", cyc - t0, DEF_P + 1);
        step(150);

        // drain
        ena = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            step(1);
            k++;
        end
        step(2);
        chk("drain", exp_q.size(), 0);
        chk("beats_seen", int'(nbeats > 20), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
